hazard_scoreboard_unit: RTL and testbench
=========================================

Name: hazard_scoreboard_unit

Overview:
Parametrised successor to the single-cycle load-use hazard detector, for the in-order RISC-V pipeline. Keeps a per-register countdown scoreboard of pending long-latency writes: loads with configurable latency, and a multi-cycle mul/div unit. From it the block generates RAW, WAW and structural stalls for the instruction in ID, a taken-branch flush and a stall performance counter. It sits beside the ID stage and drives the PC/IF-ID enables and the ID/EX bubble mux.

Parameters:
REG_AW, 5, register-address width; 2**REG_AW scoreboard entries
LAT_W, 4, width of each scoreboard countdown and of the MDU busy counter
LOAD_LAT, 1, cycles a load result is unavailable to the ID-stage consumer (1 = classic one-bubble load-use); range 1..2**LAT_W-1
MDU_LAT, 4, cycles a mul/div result is unavailable; MDU is busy for the same count; range 1..2**LAT_W-1
PERF_W, 32, stall-counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_rs1  in  REG_AW  source register 1
id_rs2  in  REG_AW  source register 2
id_rs1_used  in  1  instruction reads rs1
id_rs2_used  in  1  instruction reads rs2
id_rd  in  REG_AW  destination register
id_rd_we  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
id_is_muldiv  in  1  instruction uses the MDU
ex_branch_taken  in  1  branch/jump in EX redirects the PC this cycle
stall  out  1  hold PC and IF/ID
bubble  out  1  insert NOP into ID/EX
flush  out  1  clear IF/ID and ID/EX
mdu_busy  out  1  MDU counter nonzero
stall_cycles  out  PERF_W  count of cycles with stall=1

Behaviour:
- Reset (async): all scoreboard entries 0, MDU counter 0, stall_cycles 0. While rst=1, stall, bubble, flush and mdu_busy are 0.
- Scoreboard: sb[r] holds the cycles remaining before r is readable via forwarding. sb[0] is always 0; writes to x0 are ignored.
- Hazard terms. None are flagged for register 0.
  - raw = (id_rs1_used & sb[id_rs1]!=0) | (id_rs2_used & sb[id_rs2]!=0)
  - waw = id_rd_we & sb[id_rd]!=0
  - struct = id_is_muldiv & mdu_cnt!=0
- flush = ex_branch_taken (combinational).
- stall = id_valid & ~flush & (raw | waw | struct). bubble = stall. Flush has priority and kills the ID instruction, so there is no stall and no issue.
- Issue when id_valid & ~stall & ~flush:
  - rd_we & rd!=0 & is_load -> sb[rd] <= LOAD_LAT
  - rd_we & rd!=0 & is_muldiv -> sb[rd] <= MDU_LAT
  - is_muldiv (any rd) -> mdu_cnt <= MDU_LAT
- Every clock, each nonzero entry not being issued decrements by 1. It saturates at 0 and never wraps. mdu_cnt behaves the same way.
- Issue load takes precedence over decrement for the same entry.
- id_is_load & id_is_muldiv together is illegal; the behaviour is undefined and is flagged by a bench assertion.
- stall_cycles increments on each cycle with stall=1 and saturates at all-ones.
- Latency: stall is combinational from the ID inputs and registered state, with zero-cycle response. Consumer stall count = LAT - (issue distance - 1) cycles.
- A flush does not clear the scoreboard: the older loads and MDU ops are still in flight.
- Reset asserted mid-countdown clears all state immediately.

Decomposition:
- Shared package hazard_pkg: REG_AW default, LAT_W default, localparam REG_X0 = 0, and a latency-class encoding (LAT_NONE/LAT_LOAD/LAT_MDU).
- One natural sub-module: hazard_sb_entry, holding a single LAT_W countdown with load/decrement/saturate. It is generated 2**REG_AW-1 times; the x0 entry is tied to 0.
- The MDU counter reuses hazard_sb_entry.

Test Plan:
- Reset -> all outputs 0 and stall_cycles=0. Assert rst mid-countdown (sb[5]=3) -> the next consumer of x5 sees stall=0.
- LOAD_LAT=1: lw x1 issues, then add x3,x1,x2 in the next cycle -> stall=bubble=1 for exactly 1 cycle; an independent instruction instead -> stall=0. stall_cycles=1.
- LOAD_LAT=3: lw x4, nop, then use x4 -> stall for 2 cycles.
- Load to x0 followed by a use of x0 -> no stall. rs2_used=0 with rs2 matching a pending rd -> no stall.
- MDU_LAT=4: mul x7, then mul x8 back-to-back -> structural stall for 4 cycles with mdu_busy=1 throughout. addi x7 right after mul x7 -> WAW stall for 4 cycles.
- A hazard present while ex_branch_taken=1 -> flush=1, stall=0, and no scoreboard write for the killed instruction. A pending load from before the branch still stalls its consumer after the redirect.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard.
// Provides default register-address and countdown widths, the x0 index, and the
// latency-class encoding used to pick the scoreboard value for an issuing instruction.
package hazard_pkg;

  localparam int unsigned REG_AW_DEFAULT = 5;
  localparam int unsigned LAT_W_DEFAULT  = 4;
  localparam int unsigned REG_X0         = 0;

  typedef enum logic [1:0] {
    LAT_NONE = 2'd0,
    LAT_LOAD = 2'd1,
    LAT_MDU  = 2'd2
  } lat_class_e;

  // Load wins if both flags are set; that combination is illegal upstream.
  function automatic lat_class_e lat_class(input logic is_load, input logic is_muldiv);
    if (is_load) return LAT_LOAD;
    if (is_muldiv) return LAT_MDU;
    return LAT_NONE;
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard countdown.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   load      - overwrite the count with load_val (wins over decrement)
//   load_val  - value loaded on issue
//   count     - cycles remaining
//   busy      - count is nonzero
module hazard_sb_entry #(
  parameter int unsigned LAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic [LAT_W-1:0] count,
  output logic             busy
);

  logic [LAT_W-1:0] count_q;

  // Decrement saturates at zero so an idle entry stays idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - LAT_W'(1);
    end
  end

  assign count = count_q;
  assign busy  = (count_q != '0);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Countdown-scoreboard hazard unit for the in-order pipeline.
// Tracks pending load and mul/div writes per register and the MDU occupancy, and from
// them derives RAW, WAW and structural stalls for the instruction in ID.
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   id_valid                     - ID holds a real instruction
//   id_rs1/id_rs2, *_used        - source registers and whether they are read
//   id_rd, id_rd_we              - destination register and write enable
//   id_is_load, id_is_muldiv     - latency class of the ID instruction
//   ex_branch_taken              - EX redirects the PC this cycle
//   stall, bubble, flush         - pipeline control
//   mdu_busy                     - MDU occupancy counter nonzero
//   stall_cycles                 - saturating count of stalled cycles
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW   = REG_AW_DEFAULT,
  parameter int unsigned LAT_W    = LAT_W_DEFAULT,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned MDU_LAT  = 4,
  parameter int unsigned PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_we,
  input  logic              id_is_load,
  input  logic              id_is_muldiv,
  input  logic              ex_branch_taken,
  output logic              stall,
  output logic              bubble,
  output logic              flush,
  output logic              mdu_busy,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam int unsigned NREGS = 2 ** REG_AW;

  logic [LAT_W-1:0] sb [NREGS];
  logic [LAT_W-1:0] mdu_cnt;
  logic             mdu_nz;
  logic             raw_hit, waw_hit, struct_hit;
  logic             issue, rd_issue, mdu_issue;
  lat_class_e       cls;
  logic [LAT_W-1:0] issue_lat;
  logic [PERF_W-1:0] stall_cycles_q;

  // x0 never has a pending write, so it can never raise a hazard.
  assign sb[REG_X0] = '0;

  always_comb begin
    raw_hit    = (id_rs1_used && (sb[id_rs1] != '0)) || (id_rs2_used && (sb[id_rs2] != '0));
    waw_hit    = id_rd_we && (sb[id_rd] != '0);
    struct_hit = id_is_muldiv && mdu_nz;
  end

  // Flush kills the ID instruction, so it neither stalls nor issues.
  assign flush  = ex_branch_taken && !rst;
  assign stall  = !rst && id_valid && !ex_branch_taken && (raw_hit || waw_hit || struct_hit);
  assign bubble = stall;
  assign issue  = id_valid && !stall && !ex_branch_taken;

  always_comb begin
    cls = lat_class(id_is_load, id_is_muldiv);
    case (cls)
      LAT_LOAD: issue_lat = LAT_W'(LOAD_LAT);
      LAT_MDU:  issue_lat = LAT_W'(MDU_LAT);
      default:  issue_lat = '0;
    endcase
  end

  assign rd_issue  = issue && id_rd_we && (id_rd != REG_AW'(REG_X0)) && (cls != LAT_NONE);
  assign mdu_issue = issue && id_is_muldiv;

  for (genvar r = 1; r < NREGS; r++) begin : g_sb
    logic entry_busy;
    hazard_sb_entry #(
      .LAT_W(LAT_W)
    ) u_entry (
      .clk      (clk),
      .rst      (rst),
      .load     (rd_issue && (id_rd == REG_AW'(r))),
      .load_val (issue_lat),
      .count    (sb[r]),
      .busy     (entry_busy)
    );
  end

  hazard_sb_entry #(
    .LAT_W(LAT_W)
  ) u_mdu_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (mdu_issue),
    .load_val (LAT_W'(MDU_LAT)),
    .count    (mdu_cnt),
    .busy     (mdu_nz)
  );

  assign mdu_busy = mdu_nz && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_q <= stall_cycles_q + PERF_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench: one instance with LOAD_LAT=1 driven from a vector table, one with
// LOAD_LAT=3 for hand-written multi-cycle sequences. Both use MDU_LAT=4.
module tb_hazard_scoreboard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used, id_rd_we, id_is_load, id_is_muldiv;
  logic        ex_branch_taken;

  logic        st1, bb1, fl1, mb1;
  logic [31:0] sc1;
  logic        st3, bb3, fl3, mb3;
  logic [31:0] sc3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(
    .REG_AW(5), .LAT_W(4), .LOAD_LAT(1), .MDU_LAT(4), .PERF_W(32)
  ) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .id_is_muldiv(id_is_muldiv), .ex_branch_taken(ex_branch_taken),
    .stall(st1), .bubble(bb1), .flush(fl1), .mdu_busy(mb1), .stall_cycles(sc1)
  );

  hazard_scoreboard_unit #(
    .REG_AW(5), .LAT_W(4), .LOAD_LAT(3), .MDU_LAT(4), .PERF_W(32)
  ) dut3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .id_is_muldiv(id_is_muldiv), .ex_branch_taken(ex_branch_taken),
    .stall(st3), .bubble(bb3), .flush(fl3), .mdu_busy(mb3), .stall_cycles(sc3)
  );

  // Load and mul/div on the same instruction is illegal.
  always @(posedge clk) begin
    if (!rst && id_valid) begin
      assert (!(id_is_load && id_is_muldiv))
      else $error("illegal load+muldiv in ID");
    end
  end

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       we, ld, md, br;
    logic       exp_stall, exp_flush, exp_busy;
    int         exp_cnt;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mk(logic v, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                              logic [4:0] rd, logic we, logic ld, logic md, logic br,
                              logic st, logic fl, logic bz, int cnt);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2; t.rd = rd;
    t.we = we; t.ld = ld; t.md = md; t.br = br;
    t.exp_stall = st; t.exp_flush = fl; t.exp_busy = bz; t.exp_cnt = cnt;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(logic v, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                        logic [4:0] rd, logic we, logic ld, logic md, logic br);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_rd_we = we; id_is_load = ld; id_is_muldiv = md; ex_branch_taken = br;
  endtask

  task automatic nop();
    set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nop();
    next();
    rst = 1'b0;
  endtask

  initial begin
    // valid rs1 u1 rs2 u2 rd we ld md br | stall flush busy cnt
    vecs[0]  = mk(1, 2, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0); // lw x1
    vecs[1]  = mk(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 1, 0, 0, 0); // add x3,x1,x2: load-use
    vecs[2]  = mk(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0, 1); // released
    vecs[3]  = mk(1, 2, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1); // lw x1
    vecs[4]  = mk(1, 2, 1, 6, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1); // independent add
    vecs[5]  = mk(1, 2, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1); // lw x0
    vecs[6]  = mk(1, 0, 1, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 1); // use x0
    vecs[7]  = mk(1, 2, 1, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0, 1); // lw x9
    vecs[8]  = mk(1, 2, 1, 9, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1); // rs2=x9 unused
    vecs[9]  = mk(1, 2, 1, 3, 1, 7, 1, 0, 1, 0, 0, 0, 0, 1); // mul x7
    vecs[10] = mk(1, 2, 1, 3, 1, 8, 1, 0, 1, 0, 1, 0, 1, 1); // mul x8: structural
    vecs[11] = mk(1, 2, 1, 3, 1, 8, 1, 0, 1, 0, 1, 0, 1, 2);
    vecs[12] = mk(1, 2, 1, 3, 1, 8, 1, 0, 1, 0, 1, 0, 1, 3);
    vecs[13] = mk(1, 2, 1, 3, 1, 8, 1, 0, 1, 0, 1, 0, 1, 4);
    vecs[14] = mk(1, 2, 1, 3, 1, 8, 1, 0, 1, 0, 0, 0, 0, 5); // mul x8 issues
    vecs[15] = mk(1, 2, 1, 0, 0, 8, 1, 0, 0, 0, 1, 0, 1, 5); // addi x8: WAW
    vecs[16] = mk(1, 2, 1, 0, 0, 8, 1, 0, 0, 0, 1, 0, 1, 6);
    vecs[17] = mk(1, 2, 1, 0, 0, 8, 1, 0, 0, 0, 1, 0, 1, 7);
    vecs[18] = mk(1, 2, 1, 0, 0, 8, 1, 0, 0, 0, 1, 0, 1, 8);
    vecs[19] = mk(1, 2, 1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 9); // released
    vecs[20] = mk(1, 2, 1, 0, 0, 10, 1, 1, 0, 0, 0, 0, 0, 9); // lw x10
    vecs[21] = mk(1, 10, 1, 0, 0, 11, 1, 1, 0, 1, 0, 1, 0, 9); // lw x11 killed by branch
    vecs[22] = mk(1, 11, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 9); // x11 never written

    // Reset state, with a branch and a would-be hazard on the inputs.
    rst = 1'b1;
    set_in(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    #2;
    @(negedge clk);
    check("reset stall", {31'd0, st1}, 32'd0);
    check("reset bubble", {31'd0, bb1}, 32'd0);
    check("reset flush", {31'd0, fl1}, 32'd0);
    check("reset mdu_busy", {31'd0, mb1}, 32'd0);
    check("reset stall_cycles", sc1, 32'd0);
    next();
    rst = 1'b0;
    nop();

    for (int i = 0; i < NV; i++) begin
      set_in(vecs[i].v, vecs[i].rs1, vecs[i].u1, vecs[i].rs2, vecs[i].u2, vecs[i].rd,
             vecs[i].we, vecs[i].ld, vecs[i].md, vecs[i].br);
      @(negedge clk);
      check($sformatf("v%0d stall", i), {31'd0, st1}, {31'd0, vecs[i].exp_stall});
      check($sformatf("v%0d bubble", i), {31'd0, bb1}, {31'd0, vecs[i].exp_stall});
      check($sformatf("v%0d flush", i), {31'd0, fl1}, {31'd0, vecs[i].exp_flush});
      check($sformatf("v%0d mdu_busy", i), {31'd0, mb1}, {31'd0, vecs[i].exp_busy});
      check($sformatf("v%0d stall_cycles", i), sc1, vecs[i].exp_cnt);
      next();
    end

    // LOAD_LAT=3: lw x4, nop, use x4 -> two stall cycles.
    do_reset();
    set_in(1, 5'd2, 1, 5'd0, 0, 5'd4, 1, 1, 0, 0);
    @(negedge clk); check("l3 lw stall", {31'd0, st3}, 32'd0);
    next(); nop();
    @(negedge clk); check("l3 nop stall", {31'd0, st3}, 32'd0);
    next(); set_in(1, 5'd4, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0);
    @(negedge clk); check("l3 use stall c1", {31'd0, st3}, 32'd1);
    next();
    @(negedge clk); check("l3 use stall c2", {31'd0, st3}, 32'd1);
    next();
    @(negedge clk); check("l3 use released", {31'd0, st3}, 32'd0);
    check("l3 stall_cycles", sc3, 32'd2);
    next(); nop(); next(); next(); next();

    // Pending load survives a redirect.
    set_in(1, 5'd2, 1, 5'd0, 0, 5'd4, 1, 1, 0, 0);
    next(); set_in(1, 5'd4, 1, 5'd0, 0, 5'd3, 1, 0, 0, 1);
    @(negedge clk);
    check("br flush", {31'd0, fl3}, 32'd1);
    check("br stall", {31'd0, st3}, 32'd0);
    next(); set_in(1, 5'd4, 1, 5'd0, 0, 5'd3, 1, 0, 0, 0);
    @(negedge clk); check("br pending load stall", {31'd0, st3}, 32'd1);
    next(); nop(); next(); next(); next();

    // Reset mid-countdown: sb[5]=3 is cleared immediately.
    set_in(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0);
    next();
    rst = 1'b1;
    set_in(1, 5'd5, 1, 5'd0, 0, 5'd3, 1, 0, 0, 1);
    @(negedge clk);
    check("midrst stall", {31'd0, st3}, 32'd0);
    check("midrst flush", {31'd0, fl3}, 32'd0);
    check("midrst stall_cycles", sc3, 32'd0);
    next();
    rst = 1'b0;
    set_in(1, 5'd5, 1, 5'd0, 0, 5'd3, 1, 0, 0, 0);
    @(negedge clk); check("midrst x5 consumer", {31'd0, st3}, 32'd0);
    next(); nop();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
